// File: rtl/toggle_monitor.sv
// toggle_monitor: measures the interval between i_sig edges and tracks lock to a reference period.
// Define TOGGLE_MONITOR_SYNC_EN to add a 2-flop input synchroniser (output latency 3 instead of 1).
module toggle_monitor #(
  parameter int CNT_W  = 16,
  parameter int TOL    = 1,
  parameter int LOCK_N = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sig,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_vld,
  output logic             o_locked,
  output logic             o_err,
  output logic [7:0]       o_err_cnt
);

  localparam int               MC_W    = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);
  localparam logic [MC_W-1:0]  LOCK_V  = MC_W'(LOCK_N);

  typedef enum logic [1:0] {IDLE, ACQ, TRAIN, LOCKED} state_t;

  state_t           state_q, state_d;
  logic             sig_s, sig_d;
  logic [CNT_W-1:0] cnt_q, ref_q, ref_d, diff;
  logic [MC_W-1:0]  mc_q, mc_d;
  logic             edge_det, sat, match, load_period, err_pulse;

`ifdef TOGGLE_MONITOR_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= '0;
    else       sync_q <= {sync_q[0], i_sig};
  end

  assign sig_s = sync_q[1];
`else
  assign sig_s = i_sig;
`endif

  assign edge_det = sig_s ^ sig_d;
  // An edge landing on the saturated count is still a valid measurement.
  assign sat      = (cnt_q == CNT_MAX) && !edge_det;
  assign diff     = (cnt_q >= ref_q) ? (cnt_q - ref_q) : (ref_q - cnt_q);
  assign match    = (diff <= TOL_V);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d     = state_q;
    ref_d       = ref_q;
    mc_d        = mc_q;
    load_period = 1'b0;
    err_pulse   = 1'b0;
    if (edge_det) begin
      case (state_q)
        IDLE: state_d = ACQ;
        ACQ: begin
          ref_d       = cnt_q;
          mc_d        = '0;
          load_period = 1'b1;
          state_d     = TRAIN;
        end
        TRAIN: begin
          load_period = 1'b1;
          if (match) begin
            mc_d = mc_q + 1'b1;
            if (mc_d == LOCK_V) state_d = LOCKED;
          end else begin
            ref_d = cnt_q;
            mc_d  = '0;
          end
        end
        LOCKED: begin
          load_period = 1'b1;
          if (!match) begin
            err_pulse = 1'b1;
            ref_d     = cnt_q;
            mc_d      = '0;
            state_d   = TRAIN;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (sat && (state_q != IDLE)) begin
      state_d   = IDLE;
      err_pulse = (state_q == LOCKED);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values together.
    if (i_rst) begin
      state_q      <= IDLE;
      sig_d        <= 1'b0;
      cnt_q        <= '0;
      ref_q        <= '0;
      mc_q         <= '0;
      o_period     <= '0;
      o_period_vld <= 1'b0;
      o_locked     <= 1'b0;
      o_err        <= 1'b0;
      o_err_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      sig_d        <= sig_s;
      ref_q        <= ref_d;
      mc_q         <= mc_d;
      if (edge_det)              cnt_q <= CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      if (load_period) o_period <= cnt_q;
      o_period_vld <= load_period;
      o_locked     <= (state_d == LOCKED);
      o_err        <= err_pulse;
      if (i_clr)                             o_err_cnt <= '0;
      else if (err_pulse && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_toggle_monitor.sv
// Self-checking bench for toggle_monitor: table-driven edge vectors scored through a queue,
// plus hand-written sequences for reset, counter saturation and error-count saturation.
module tb_toggle_monitor;

`ifdef TOGGLE_MONITOR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, sig, clr, sig6;
  logic [15:0] period;
  logic        vld, locked, err;
  logic [7:0]  err_cnt;
  logic [5:0]  period6;
  logic        vld6, locked6, err6;
  logic [7:0]  err_cnt6;

  typedef struct {
    int gap; int vld; int period; int locked; int err; int ecnt; int clr;
  } vec_t;
  typedef struct {
    int due; int vld; int period; int locked; int err; int ecnt;
  } exp_t;

  exp_t sb[$];
  vec_t tab_a[19];
  vec_t v;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  toggle_monitor dut (
    .i_clk(clk), .i_rst(rst), .i_sig(sig), .i_clr(clr),
    .o_period(period), .o_period_vld(vld), .o_locked(locked),
    .o_err(err), .o_err_cnt(err_cnt)
  );

  toggle_monitor #(.CNT_W(6)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_sig(sig6), .i_clr(1'b0),
    .o_period(period6), .o_period_vld(vld6), .o_locked(locked6),
    .o_err(err6), .o_err_cnt(err_cnt6)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Toggle i_sig gap cycles after the previous toggle and queue the expected outputs.
  task automatic drive_edge(input vec_t d);
    exp_t e;
    repeat (d.gap) begin @(posedge clk); #1; end
    sig = ~sig;
    e = '{cyc + LAT, d.vld, d.period, d.locked, d.err, d.ecnt};
    sb.push_back(e);
    if (d.clr != 0) fork
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
      end
    join_none
  endtask

  task automatic wait_cyc(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic toggle6(input int gap, output int k);
    repeat (gap) begin @(posedge clk); #1; end
    sig6 = ~sig6;
    k = cyc;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("period_vld", 32'(vld), 32'(e.vld));
      check("period", 32'(period), 32'(e.period));
      check("locked", 32'(locked), 32'(e.locked));
      check("err", 32'(err), 32'(e.err));
      check("err_cnt", 32'(err_cnt), 32'(e.ecnt));
    end else begin
      check("quiet_pulses", 32'({vld, err}), 32'(0));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k, t_err, ecnt, b;

    //            gap vld per lck err ecnt clr
    tab_a[0]  = '{10, 0,  0, 0,  0,  0,  0};
    tab_a[1]  = '{25, 1, 25, 0,  0,  0,  0};
    tab_a[2]  = '{25, 1, 25, 0,  0,  0,  0};
    tab_a[3]  = '{25, 1, 25, 0,  0,  0,  0};
    tab_a[4]  = '{25, 1, 25, 1,  0,  0,  0};
    tab_a[5]  = '{25, 1, 25, 1,  0,  0,  0};
    tab_a[6]  = '{26, 1, 26, 1,  0,  0,  0};
    tab_a[7]  = '{25, 1, 25, 1,  0,  0,  0};
    tab_a[8]  = '{30, 1, 30, 0,  1,  1,  0};
    tab_a[9]  = '{30, 1, 30, 0,  0,  1,  0};
    tab_a[10] = '{30, 1, 30, 0,  0,  1,  0};
    tab_a[11] = '{30, 1, 30, 1,  0,  1,  0};
    tab_a[12] = '{31, 1, 31, 1,  0,  1,  0};
    tab_a[13] = '{29, 1, 29, 1,  0,  1,  0};
    tab_a[14] = '{28, 1, 28, 0,  1,  2,  0};
    tab_a[15] = '{40, 1, 40, 0,  0,  2,  0};
    tab_a[16] = '{40, 1, 40, 0,  0,  2,  0};
    tab_a[17] = '{40, 1, 40, 0,  0,  2,  0};
    tab_a[18] = '{40, 1, 40, 1,  0,  2,  0};

    rst = 1'b1; sig = 1'b0; clr = 1'b0; sig6 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_period", 32'(period), 32'(0));
    check("init_vld", 32'(vld), 32'(0));
    check("init_locked", 32'(locked), 32'(0));
    check("init_err", 32'(err), 32'(0));
    check("init_err_cnt", 32'(err_cnt), 32'(0));
    #2 rst = 1'b0;

    for (int i = 0; i < 19; i++) drive_edge(tab_a[i]);

    // CNT_W=6 instance: lock at 20, then hold i_sig until the counter saturates.
    @(posedge clk); #1;
    sig6 = 1'b1;
    for (int i = 0; i < 4; i++) toggle6(20, k);
    wait_cyc(k + LAT);
    check("c6_locked", 32'(locked6), 32'(1));
    check("c6_period", 32'(period6), 32'(20));
    check("c6_vld", 32'(vld6), 32'(1));
    t_err = -1;
    for (int i = 0; i < 100 && t_err < 0; i++) begin
      @(negedge clk);
      if (err6) t_err = cyc;
    end
    check("c6_sat_err_cycle", 32'(t_err), 32'(k + 63 + LAT));
    check("c6_sat_locked", 32'(locked6), 32'(0));
    check("c6_sat_err_cnt", 32'(err_cnt6), 32'(1));
    toggle6(5, k);
    wait_cyc(k + LAT);
    check("c6_idle_no_vld", 32'(vld6), 32'(0));
    toggle6(10 - LAT, k);
    wait_cyc(k + LAT);
    check("c6_acq_vld", 32'(vld6), 32'(1));
    check("c6_acq_period", 32'(period6), 32'(10));
    toggle6(63 - LAT, k);
    wait_cyc(k + LAT);
    check("c6_edge_at_sat_vld", 32'(vld6), 32'(1));
    check("c6_edge_at_sat_period", 32'(period6), 32'(63));
    check("c6_edge_at_sat_err", 32'(err6), 32'(0));
    toggle6(63 - LAT, k);
    wait_cyc(k + LAT);
    check("c6_after_sat_edge_vld", 32'(vld6), 32'(1));

    // Asynchronous reset mid-lock, held for 37 cycles.
    @(negedge clk);
    check("locked_before_reset", 32'(locked), 32'(1));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_period", 32'(period), 32'(0));
    check("rst_vld", 32'(vld), 32'(0));
    check("rst_locked", 32'(locked), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_err_cnt", 32'(err_cnt), 32'(0));
    sig = 1'b0;
    repeat (37) @(posedge clk);
    #3 rst = 1'b0;
    v = '{12, 0,  0, 0, 0, 0, 0}; drive_edge(v);
    v = '{25, 1, 25, 0, 0, 0, 0}; drive_edge(v);

    // Lock at interval 4, then alternate 8/4 to generate repeated losses of lock.
    v = '{4, 1, 4, 0, 0, 0, 0};
    drive_edge(v); drive_edge(v); drive_edge(v);
    v.locked = 1; drive_edge(v);
    for (int n = 1; n <= 258; n++) begin
      b = (n % 2 == 1) ? 8 : 4;
      ecnt = (n <= 255) ? n : (n == 256) ? 255 : (n == 257) ? 0 : 1;
      v = '{b, 1, b, 0, 1, ecnt, (n == 257) ? 1 : 0}; drive_edge(v);
      v = '{b, 1, b, 0, 0, ecnt, 0};                  drive_edge(v); drive_edge(v);
      v = '{b, 1, b, 1, 0, ecnt, 0};                  drive_edge(v);
    end

    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
